// File: rtl/ext_pipe.sv
// Registered immediate-extension stage with a 2-entry skid buffer (main + skid).
// Optional stall counter port enabled by defining EXT_PIPE_STATS_EN.
module ext_pipe #(
  parameter int IMM_W = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IMM_W-1:0] imm,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [2:0]       out_op
`ifdef EXT_PIPE_STATS_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  localparam int E = OUT_W - IMM_W;

  logic [OUT_W-1:0] ext;
  logic [OUT_W-1:0] sext;
  logic             s_valid;
  logic [OUT_W-1:0] s_data;
  logic [2:0]       s_op;
  logic             in_xfer;
  logic             m_free;

  always_comb begin
    sext = {{E{imm[IMM_W-1]}}, imm};
    ext  = {{E{1'b0}}, imm};
    case (op)
      3'b001:  ext = sext;
      3'b010:  ext = {imm, {E{1'b0}}};
      3'b011:  ext = {sext[OUT_W-3:0], 2'b00};
      default: ext = {{E{1'b0}}, imm};
    endcase
  end

  // in_ready comes straight from the skid flop, so out_ready never reaches it combinationally
  assign in_ready = ~s_valid;
  assign in_xfer  = in_valid & in_ready;
  assign m_free   = ~out_valid | out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_op    <= '0;
      s_valid   <= 1'b0;
      s_data    <= '0;
      s_op      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      s_valid   <= 1'b0;
    end else if (m_free) begin
      if (s_valid) begin
        out_valid <= 1'b1;
        out_data  <= s_data;
        out_op    <= s_op;
        s_valid   <= in_xfer;
        if (in_xfer) begin
          s_data <= ext;
          s_op   <= op;
        end
      end else begin
        out_valid <= in_xfer;
        if (in_xfer) begin
          out_data <= ext;
          out_op   <= op;
        end
      end
    end else if (in_xfer) begin
      s_valid <= 1'b1;
      s_data  <= ext;
      s_op    <= op;
    end
  end

`ifdef EXT_PIPE_STATS_EN
  // Saturating count of stalled cycles; flush deliberately leaves it alone
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ext_pipe.sv
// Scoreboard-based directed bench for ext_pipe; expected results are queued on
// acceptance and compared when the stage hands them downstream.
module tb_ext_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] imm;
  logic [2:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_op;
`ifdef EXT_PIPE_STATS_EN
  logic [31:0] stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int popCount = 0;
  logic [34:0] sb[$];

  always #5 clk = ~clk;

  ext_pipe #(.IMM_W(16), .OUT_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm       (imm),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_op    (out_op)
`ifdef EXT_PIPE_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs just after a falling edge, score the transfers
  // that will happen at the coming rising edge, then advance to the next falling edge.
  task automatic applyStimulus(input logic iv, input logic [15:0] im, input logic [2:0] o,
                               input logic [31:0] expData, input logic ordy, input logic fl);
    logic [34:0] head;
    in_valid  = iv;
    imm       = im;
    op        = o;
    out_ready = ordy;
    flush     = fl;
    #1;
    if (out_valid && out_ready && !fl) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_output", {29'd0, out_valid}, 32'd0);
      end else begin
        head = sb.pop_front();
        popCount++;
        checkOutput("out_data", out_data, head[31:0]);
        checkOutput("out_op", {29'd0, out_op}, {29'd0, head[34:32]});
      end
    end
    if (iv && in_ready && !fl) sb.push_back({o, expData});
    if (fl) sb.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; imm = '0; op = '0; out_ready = 1'b0;
    #3;
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_out_data", out_data, 32'd0);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Extension modes, full-rate with downstream always ready
    applyStimulus(1'b1, 16'h8001, 3'b001, 32'hFFFF8001, 1'b1, 1'b0);
    checkOutput("latency_out_valid", {31'd0, out_valid}, 32'd1);
    applyStimulus(1'b1, 16'h8001, 3'b000, 32'h00008001, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h1234, 3'b010, 32'h12340000, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'hFFFF, 3'b011, 32'hFFFFFFFC, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h0004, 3'b011, 32'h00000010, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h00FF, 3'b111, 32'h000000FF, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h4001, 3'b011, 32'h00010004, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h8000, 3'b101, 32'h00008000, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 3'b000, 32'h0, 1'b1, 1'b0);
    checkOutput("modes_drained", sb.size(), 32'd0);

    // Backpressure fills both entries, then drains in order
    applyStimulus(1'b1, 16'h0001, 3'b000, 32'h00000001, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0002, 3'b000, 32'h00000002, 1'b0, 1'b0);
    checkOutput("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    applyStimulus(1'b1, 16'h0BAD, 3'b000, 32'h00000BAD, 1'b0, 1'b0);
    checkOutput("bp_still_full", {31'd0, in_ready}, 32'd0);
    applyStimulus(1'b0, 16'h0000, 3'b000, 32'h0, 1'b1, 1'b0);
    checkOutput("bp_b_valid", {31'd0, out_valid}, 32'd1);
    applyStimulus(1'b0, 16'h0000, 3'b000, 32'h0, 1'b1, 1'b0);
    checkOutput("bp_in_ready_high", {31'd0, in_ready}, 32'd1);
    checkOutput("bp_empty", {31'd0, out_valid}, 32'd0);
    checkOutput("bp_drained", sb.size(), 32'd0);

    // Streaming: eight back-to-back transfers with no bubbles
    popCount = 0;
    for (int i = 0; i < 8; i++) begin
      checkOutput("stream_in_ready", {31'd0, in_ready}, 32'd1);
      applyStimulus(1'b1, 16'(i), 3'b000, 32'(i), 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 16'h0000, 3'b000, 32'h0, 1'b1, 1'b0);
    checkOutput("stream_count", popCount, 32'd8);

    // Flush with both entries full and a new offer
    applyStimulus(1'b1, 16'h00AA, 3'b000, 32'h000000AA, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h00BB, 3'b000, 32'h000000BB, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h00CC, 3'b000, 32'h000000CC, 1'b0, 1'b1);
    checkOutput("flush_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("flush_in_ready", {31'd0, in_ready}, 32'd1);
    // Flush while empty must discard an accepted-looking input
    applyStimulus(1'b1, 16'h00DD, 3'b000, 32'h000000DD, 1'b1, 1'b1);
    checkOutput("flush_drop_input", {31'd0, out_valid}, 32'd0);
    applyStimulus(1'b0, 16'h0000, 3'b000, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 3'b000, 32'h0, 1'b1, 1'b0);
    checkOutput("flush_stays_empty", {31'd0, out_valid}, 32'd0);

    // Post-flush sanity
    applyStimulus(1'b1, 16'hFFFE, 3'b001, 32'hFFFFFFFE, 1'b1, 1'b0);
    for (int k = 0; k < 20 && sb.size() != 0; k++) begin
      applyStimulus(1'b0, 16'h0000, 3'b000, 32'h0, 1'b1, 1'b0);
    end
    checkOutput("drain_bound", sb.size(), 32'd0);

    // Reset mid-stall, clearing stats first so the stall count is exact
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 16'h0011, 3'b000, 32'h00000011, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0022, 3'b000, 32'h00000022, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 3'b000, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 3'b000, 32'h0, 1'b0, 1'b0);
    checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
`ifdef EXT_PIPE_STATS_EN
    checkOutput("stall_cnt_3", stall_cnt, 32'd3);
`endif
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midreset_out_data", out_data, 32'd0);
    checkOutput("midreset_out_op", {29'd0, out_op}, 32'd0);
    checkOutput("midreset_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef EXT_PIPE_STATS_EN
    checkOutput("midreset_stall_cnt", stall_cnt, 32'd0);
`endif
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 16'h0000, 3'b000, 32'h0, 1'b1, 1'b0);
    checkOutput("after_reset_empty", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
